// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared frame FSM states, data width and bit-period helper for uart8_tx_queue
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Truncating divide; clamped to one cycle so a too-high baud rate still elaborates.
    function automatic int calc_div(input int clock_rate, input int baud_rate);
        int div;
        div = clock_rate / baud_rate;
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart8_tx_queue_baud_tick_gen.sv
// rtl/uart8_tx_queue_baud_tick_gen.sv - DIV-cycle bit timer; tick marks the last cycle of each frame bit
module baud_tick_gen #(
    parameter int DIV = 1250
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart8_tx_queue.sv
// rtl/uart8_tx_queue.sv - byte-queued 8-bit UART transmitter; define UART_TX_PARITY_EN for an even-parity bit
module uart8_tx_queue #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txEn,
    input  logic       wrEn,
    input  logic [7:0] in,
    output logic       full,
    output logic       out,
    output logic       txBusy,
    output logic       txDone
);

    import uart_pkg::*;

    localparam int DIV   = calc_div(CLOCK_RATE, BAUD_RATE);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    tx_state_e        state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic empty;
    logic push;
    logic pop;
    logic bit_tick;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = wrEn && !full;
    // Occupancy is sampled before this edge's write, so a byte never bypasses the queue.
    assign pop   = txEn && !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_tick));

    baud_tick_gen #(
        .DIV(DIV)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .en     (txBusy),
        .restart(pop),
        .tick   (bit_tick)
    );

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (pop) begin
            state_d   = START;
            bit_idx_d = '0;
            shift_d   = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_d     = ^mem_q[rd_ptr_q];
`endif
        end else if (bit_tick) begin
            case (state_q)
                START: state_d = DATA;
                DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY:  state_d = STOP;
`endif
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The line level is chosen from the next state so that out is a plain flop.
    always_comb begin
        done_d = (state_q == STOP) && bit_tick;
        out_d  = 1'b1;
        case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  out_d = par_d;
`endif
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            out_q     <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign out    = out_q;
    assign txBusy = (state_q != IDLE);
    assign txDone = done_q;

endmodule

// File: tb/tb_uart8_tx_queue.sv
// tb/tb_uart8_tx_queue.sv - randomized and directed bench for uart8_tx_queue against a frame-level model
module tb_uart8_tx_queue;

    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 97_000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int DEPTH  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB       = 11;
    localparam int BUSY_LIT = 1353;
    localparam logic [10:0] EXP_56 = 11'h4AC;
    localparam logic [10:0] EXP_57 = 11'h6AE;
`else
    localparam int NB       = 10;
    localparam int BUSY_LIT = 1230;
    localparam logic [10:0] EXP_56 = 11'h2AC;
    localparam logic [10:0] EXP_57 = 11'h2AE;
`endif
    localparam int FRAME = NB * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] in_b = 8'h00;
    logic       full;
    logic       out_s;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    uart8_tx_queue #(
        .CLOCK_RATE(CLK_HZ),
        .BAUD_RATE (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .txEn  (tx_en),
        .wrEn  (wr_en),
        .in    (in_b),
        .full  (full),
        .out   (out_s),
        .txBusy(tx_busy),
        .txDone(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a byte queue plus the time elapsed in the current frame.
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic       m_bits [11];
    bit         m_active  = 1'b0;
    int         m_elapsed = 0;
    bit         m_done    = 1'b0;
    bit         m_full_pre;
    bit         m_ending;
    logic [7:0] m_byte;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
            m_done    = 1'b0;
        end else begin
            m_full_pre = (mq.size() == DEPTH);
            m_ending   = m_active && (m_elapsed == FRAME - 1);
            m_done     = m_ending;
            if ((!m_active || m_ending) && tx_en && (mq.size() > 0)) begin
                m_byte = mq.pop_front();
                sent.push_back(m_byte);
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[1 + i] = m_byte[i];
`ifdef UART_TX_PARITY_EN
                m_bits[9] = ^m_byte;
`endif
                m_bits[NB - 1] = 1'b1;
                m_active  = 1'b1;
                m_elapsed = 0;
            end else if (m_ending) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_elapsed++;
            end
            if (wr_en && !m_full_pre) mq.push_back(in_b);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out", out_s, m_active ? m_bits[m_elapsed / DIV] : 1'b1);
            check("cyc_txBusy", tx_busy, m_active);
            check("cyc_txDone", tx_done, m_done);
            check("cyc_full", full, mq.size() == DEPTH);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out", out_s, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_full", full, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        in_b  = b;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Called at the first negedge of a frame; returns at the first idle negedge.
    task automatic measure_frame(output logic [10:0] bits, output int busy_cyc, output int dones);
        int cyc;
        cyc   = 0;
        bits  = '0;
        dones = 0;
        while (tx_busy && cyc < FRAME + 10) begin
            if ((cyc % DIV == DIV / 2) && (cyc / DIV < 11)) bits[cyc / DIV] = out_s;
            if (tx_done) dones++;
            cyc++;
            @(negedge clk);
        end
        busy_cyc = cyc;
    endtask

    task automatic single_frame(input logic [7:0] b, input logic [10:0] exp_bits, input string tag);
        logic [10:0] bits;
        int busy_cyc;
        int dones;
        write_byte(b);
        check({tag, "_no_bypass"}, tx_busy, 1'b0);
        @(negedge clk);
        check({tag, "_start_busy"}, tx_busy, 1'b1);
        check({tag, "_start_out"}, out_s, 1'b0);
        measure_frame(bits, busy_cyc, dones);
        check({tag, "_bits"}, bits, exp_bits);
        check({tag, "_busy_cycles"}, busy_cyc, BUSY_LIT);
        check({tag, "_done_in_frame"}, dones, 0);
        check({tag, "_done_pulse"}, tx_done, 1'b1);
        @(negedge clk);
        check({tag, "_done_cleared"}, tx_done, 1'b0);
    endtask

    initial begin
        logic [7:0] burst [4];
        int cyc;
        int dones;
        int wr_lim;
        burst = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

        #2 rst = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("idle_out", out_s, 1'b1);

        tx_en = 1'b1;
        single_frame(8'h56, EXP_56, "f56");
        single_frame(8'h57, EXP_57, "f57");

        // Fill the queue with transmission held off, then overflow it.
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_byte(burst[i]);
            check($sformatf("burst_full_%0d", i), full, (i == 3) ? 1'b1 : 1'b0);
        end
        write_byte(8'h11);
        check("overflow_full", full, 1'b1);
        repeat (10) @(negedge clk);
        check("held_out", out_s, 1'b1);
        check("held_busy", tx_busy, 1'b0);
        sent.delete();
        tx_en = 1'b1;
        @(negedge clk);
        check("burst_start", tx_busy, 1'b1);
        cyc = 0;
        dones = 0;
        while (tx_busy && cyc < 4 * FRAME + 50) begin
            if (tx_done) dones++;
            cyc++;
            @(negedge clk);
        end
        check("burst_busy_cycles", cyc, 4 * BUSY_LIT);
        check("burst_inner_dones", dones, 3);
        check("burst_final_done", tx_done, 1'b1);
        check("burst_sent_count", sent.size(), 4);
        for (int i = 0; i < 4 && i < sent.size(); i++) check($sformatf("burst_order_%0d", i), sent[i], burst[i]);

        // Two bytes queued with txEn low, then a reset partway into the first frame.
        tx_en = 1'b0;
        write_byte(8'h9C);
        write_byte(8'h42);
        repeat (20) @(negedge clk);
        check("two_held_out", out_s, 1'b1);
        check("two_held_busy", tx_busy, 1'b0);
        tx_en = 1'b1;
        @(negedge clk);
        check("two_start_busy", tx_busy, 1'b1);
        check("two_start_out", out_s, 1'b0);
        repeat (300) @(negedge clk);
        do_reset();
        cyc = 0;
        dones = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (tx_busy) cyc++;
            if (tx_done) dones++;
            @(negedge clk);
        end
        check("post_rst_busy", cyc, 0);
        check("post_rst_done", dones, 0);

        // Randomized traffic at three write densities, with occasional txEn toggles.
        for (int phase = 0; phase < 3; phase++) begin
            wr_lim = (phase == 0) ? 2 : ((phase == 1) ? 8 : 200);
            for (int i = 0; i < 10000; i++) begin
                wr_en = ($urandom_range(0, 1999) < wr_lim);
                in_b  = 8'($urandom);
                if ($urandom_range(0, 2999) == 0) tx_en = ~tx_en;
                @(negedge clk);
            end
            wr_en = 1'b0;
            tx_en = 1'b1;
        end
        if (phase_rst_check()) check("final_idle_out", out_s, m_active ? m_bits[m_elapsed / DIV] : 1'b1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic bit phase_rst_check();
        return !rst;
    endfunction

endmodule

// File: doc/uart8_tx_queue.md
UART8_TX_QUEUE -- requirements
Module: uart8_tx_queue

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 12000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate in baud.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, byte queue depth; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port txEn, input, 1 bit: permits a new frame to start.
REQ-007 SHALL have port wrEn, input, 1 bit: write strobe, one byte per cycle.
REQ-008 SHALL have port in, input, 8 bits: byte to enqueue.
REQ-009 SHALL have port full, output, 1 bit: queue holds FIFO_DEPTH bytes.
REQ-010 SHALL have port out, output, 1 bit: serial line, idle high, registered.
REQ-011 SHALL have port txBusy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port txDone, output, 1 bit: one-cycle pulse after each stop bit completes.

Function
REQ-013 SHALL use bit period DIV = CLOCK_RATE / BAUD_RATE, truncated (1250 at the defaults); every frame bit holds for exactly DIV cycles.
REQ-014 SHALL sequence the frame FSM through IDLE -> START -> DATA (8 bits, LSB first) -> [PARITY] -> STOP -> IDLE.
REQ-015 SHALL, at an edge with wrEn=1 and full=0, enqueue in; a write while full=1 is dropped with no state change.
REQ-016 SHALL, at an edge in IDLE with txEn=1 and queue non-empty, pop the head into the shift register, enter START and drive out=0 from that edge.
REQ-017 SHALL, on a write to an empty queue, start no earlier than the following edge (no same-cycle bypass).
REQ-018 SHALL, on a simultaneous write and pop with the queue non-empty and not full, keep the count unchanged and preserve order.
REQ-019 SHALL, on a simultaneous write and pop with full=1, drop the write (full is evaluated before the pop).
REQ-020 SHALL, when the last STOP cycle ends, assert txDone for exactly one cycle.
REQ-021 SHALL, in that same cycle, start the next frame back-to-back (START) if txEn=1 and the queue is non-empty, with no extra idle cycle; otherwise return to IDLE.
REQ-022 SHALL, if txEn falls mid-frame, complete the current frame and then hold IDLE.
REQ-023 SHALL assert txBusy in every state except IDLE.
REQ-024 SHALL drive out=1 in IDLE.
REQ-025 SHALL wrap the read/write pointers modulo FIFO_DEPTH and use an occupancy counter of clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 SHALL, on rst=1 (asynchronous), force out=1, txBusy=0, txDone=0, full=0, FSM to IDLE, pointers, counter and baud counter to 0.
REQ-027 SHALL, on reset mid-frame, abort the frame, discard queued bytes and not pulse txDone.

Configuration
REQ-028 SHALL, with macro UART_TX_PARITY_EN defined, insert an even-parity bit (XOR of the 8 data bits) of DIV cycles between D7 and STOP, giving an 11-bit frame.
REQ-029 SHALL, without UART_TX_PARITY_EN, omit the PARITY state entirely, giving a 10-bit frame.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, START, DATA, PARITY, STOP) and the constant DATA_BITS=8 in shared package uart_pkg.
REQ-031 SHALL use one sub-module, baud_tick_gen, a DIV-cycle counter restarted on frame start that emits the bit-end tick.

Verification
REQ-032 SHALL cover: rst released, wrEn with in=0x56, txEn=1 -> out = 0,0,1,1,0,1,0,1,0,1, each 1250 cycles; txDone one pulse; txBusy high for exactly 12500 cycles.
REQ-033 SHALL cover: 0x56 with UART_TX_PARITY_EN defined -> parity bit 0, frame 13750 cycles; 0x57 -> parity bit 1.
REQ-034 SHALL cover: write 0xA5, 0x3C, 0xFF, 0x00 back-to-back, txEn=1 -> four frames with no idle gap, in order; full=1 only after the 4th write when no pop intervened.
REQ-035 SHALL cover: queue full plus a 5th write of 0x11 -> 0x11 never transmitted; count stays 4.
REQ-036 SHALL cover: rst asserted 3000 cycles into a frame -> out=1 immediately; no txDone; queue empty; no further frame.
REQ-037 SHALL cover: txEn=0 with 2 bytes queued -> out stays 1; txEn raised -> first frame starts on the next edge.
